// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: memory load returns take priority over
// buffered ALU/JAL results; a pending-load scoreboard drives the decode hazard.
module regfile_wb_arbiter #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic                       alu_jal,
    input  logic [W-1:0]               alu_data,
    input  logic                       ld_issue,
    input  logic [4:0]                 ld_rd,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_rd,
    input  logic [W-1:0]               mem_data,
    input  logic [4:0]                 rr1,
    input  logic [4:0]                 rr2,
    output logic                       hazard,
    output logic                       rf_regwrite,
    output logic [4:0]                 rf_wr,
    output logic [W-1:0]               rf_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [4:0]    fifo_rd   [DEPTH];
    logic [W-1:0]  fifo_data [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [31:0]   busy;
    logic [31:0]   busy_next;

    logic [4:0]    erd;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_hit1;
    logic          fifo_hit2;
    logic [AW-1:0] idx;

    assign erd        = alu_jal ? 5'd31 : alu_rd;
    assign alu_ready  = (count < CW'(DEPTH)) && !busy[erd];
    assign accept     = alu_valid && alu_ready;
    assign push       = accept && (erd != 5'd0);
    assign pop        = !mem_valid && (count != CW'(0));
    assign fifo_count = count;

    // Scoreboard update: a new issue wins over a same-register return.
    always_comb begin
        busy_next = busy;
        if (mem_valid) begin
            busy_next[mem_rd] = 1'b0;
        end
        if (ld_issue && (ld_rd != 5'd0)) begin
            busy_next[ld_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Look through the live FIFO entries for a pending write to either read port.
    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        idx       = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rptr + AW'(i);
            if (CW'(i) < count) begin
                if (fifo_rd[idx] == rr1) fifo_hit1 = 1'b1;
                if (fifo_rd[idx] == rr2) fifo_hit2 = 1'b1;
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (rr1 != 5'd0 && (busy[rr1] || fifo_hit1 || (rf_regwrite && rf_wr == rr1))) begin
            hazard = 1'b1;
        end
        if (rr2 != 5'd0 && (busy[rr2] || fifo_hit2 || (rf_regwrite && rf_wr == rr2))) begin
            hazard = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            busy  <= '0;
        end else begin
            busy <= busy_next;
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage carries no reset; only entries below count are ever consulted.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo_rd[wptr]   <= erd;
            fifo_data[wptr] <= alu_data;
        end
    end

    // Write-port register: load return, else FIFO head, else idle holding address/data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_regwrite <= 1'b0;
            rf_wr       <= '0;
            rf_wdata    <= '0;
        end else if (mem_valid) begin
            rf_regwrite <= (mem_rd != 5'd0);
            rf_wr       <= mem_rd;
            rf_wdata    <= mem_data;
        end else if (pop) begin
            rf_regwrite <= 1'b1;
            rf_wr       <= fifo_rd[rptr];
            rf_wdata    <= fifo_data[rptr];
        end else begin
            rf_regwrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// every cycle against a queue-based model of the writeback arbiter.
module tb_regfile_wb_arbiter;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;

    logic         clock;
    logic         reset;
    logic         alu_valid;
    logic         alu_ready;
    logic [4:0]   alu_rd;
    logic         alu_jal;
    logic [W-1:0] alu_data;
    logic         ld_issue;
    logic [4:0]   ld_rd;
    logic         mem_valid;
    logic [4:0]   mem_rd;
    logic [W-1:0] mem_data;
    logic [4:0]   rr1;
    logic [4:0]   rr2;
    logic         hazard;
    logic         rf_regwrite;
    logic [4:0]   rf_wr;
    logic [W-1:0] rf_wdata;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .alu_jal(alu_jal), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_rd(ld_rd),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .rr1(rr1), .rr2(rr2), .hazard(hazard),
        .rf_regwrite(rf_regwrite), .rf_wr(rf_wr), .rf_wdata(rf_wdata),
        .fifo_count(fifo_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending ALU writes as a queue, scoreboard as a bit array.
    typedef struct {
        logic [4:0]   rd;
        logic [W-1:0] d;
    } ent_t;

    ent_t         q[$];
    bit           mbusy[32];
    bit           mvalid = 0;
    logic         m_we;
    logic [4:0]   m_wr;
    logic [W-1:0] m_wd;

    function automatic bit m_ready(input logic [4:0] rd, input logic jal);
        logic [4:0] e;
        e = jal ? 5'd31 : rd;
        return (q.size() < DEPTH) && !mbusy[e];
    endfunction

    function automatic bit m_haz1(input logic [4:0] r);
        if (r == 5'd0) return 0;
        if (mbusy[r]) return 1;
        foreach (q[i]) if (q[i].rd == r) return 1;
        return m_we && (m_wr == r);
    endfunction

    always @(posedge clock) begin
        logic [4:0] e;
        bit rdy;
        ent_t h;
        if (reset) begin
            q.delete();
            foreach (mbusy[i]) mbusy[i] = 0;
            m_we = 0; m_wr = '0; m_wd = '0;
            mvalid = 1;
        end else if (mvalid) begin
            e   = alu_jal ? 5'd31 : alu_rd;
            rdy = m_ready(alu_rd, alu_jal);
            if (mem_valid) begin
                m_we = (mem_rd != 5'd0); m_wr = mem_rd; m_wd = mem_data;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                m_we = 1; m_wr = h.rd; m_wd = h.d;
            end else begin
                m_we = 0;
            end
            if (alu_valid && rdy && e != 5'd0) begin
                h.rd = e; h.d = alu_data;
                q.push_back(h);
            end
            if (mem_valid) mbusy[mem_rd] = 0;
            if (ld_issue && ld_rd != 5'd0) mbusy[ld_rd] = 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (mvalid) begin
            chk("rf_regwrite", 64'(rf_regwrite), 64'(m_we));
            if (m_we) begin
                chk("rf_wr", 64'(rf_wr), 64'(m_wr));
                chk("rf_wdata", 64'(rf_wdata), 64'(m_wd));
            end
            chk("fifo_count", 64'(fifo_count), 64'(q.size()));
            chk("alu_ready", 64'(alu_ready), 64'(m_ready(alu_rd, alu_jal)));
            chk("hazard", 64'(hazard), 64'(m_haz1(rr1) || m_haz1(rr2)));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_jal = 0; ld_issue = 0; mem_valid = 0;
    endtask

    initial begin
        reset = 1; idle();
        alu_rd = '0; alu_data = '0; ld_rd = '0; mem_rd = '0; mem_data = '0;
        rr1 = '0; rr2 = '0;
        cyc(); cyc();
        chk("reset_regwrite", 64'(rf_regwrite), 64'd0);
        chk("reset_wr", 64'(rf_wr), 64'd0);
        chk("reset_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_count", 64'(fifo_count), 64'd0);
        reset = 0;

        // ALU write latency and hazard window
        alu_valid = 1; alu_rd = 5; alu_data = 32'h11; rr1 = 5;
        cyc(); idle();
        chk("t1_haz_c1", 64'(hazard), 64'd1);
        cyc();
        chk("t1_we", 64'(rf_regwrite), 64'd1);
        chk("t1_wr", 64'(rf_wr), 64'd5);
        chk("t1_wd", 64'(rf_wdata), 64'h11);
        chk("t1_haz_c2", 64'(hazard), 64'd1);
        cyc();
        chk("t1_haz_c3", 64'(hazard), 64'd0);
        chk("t1_we_off", 64'(rf_regwrite), 64'd0);
        rr1 = 0;

        // JAL forced to r31, then erd==0 consumed silently
        alu_valid = 1; alu_rd = 7; alu_jal = 1; alu_data = 32'h400;
        cyc(); idle(); cyc();
        chk("jal_wr", 64'(rf_wr), 64'd31);
        chk("jal_wd", 64'(rf_wdata), 64'h400);
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55; #1;
        chk("r0_ready", 64'(alu_ready), 64'd1);
        cyc(); idle(); cyc();
        chk("r0_nowrite", 64'(rf_regwrite), 64'd0);
        cyc();

        // ALU write held off behind a pending load to the same register
        ld_issue = 1; ld_rd = 9;
        cyc(); idle();
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99; #1;
        chk("ld_block", 64'(alu_ready), 64'd0);
        cyc(); cyc();
        chk("ld_block2", 64'(alu_ready), 64'd0);
        mem_valid = 1; mem_rd = 9; mem_data = 32'hAB;
        cyc(); mem_valid = 0;
        chk("ld_wr", 64'(rf_wr), 64'd9);
        chk("ld_wd", 64'(rf_wdata), 64'hAB);
        cyc(); alu_valid = 0; cyc();
        chk("ld_alu_wr", 64'(rf_wr), 64'd9);
        chk("ld_alu_wd", 64'(rf_wdata), 64'h99);
        chk("ld_alu_we", 64'(rf_regwrite), 64'd1);
        cyc();

        // FIFO fill under a memory stream, then in-order drain
        mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(32'hA0 + i);
            cyc();
        end
        alu_rd = 14; #1;
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_ready", 64'(alu_ready), 64'd0);
        cyc(); alu_valid = 0;
        cyc(); mem_valid = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("drain_wr", 64'(rf_wr), 64'(10 + i));
            chk("drain_wd", 64'(rf_wdata), 64'(32'hA0 + i));
        end
        cyc();

        // Same-cycle issue and return on r3: issue wins
        ld_issue = 1; ld_rd = 3; mem_valid = 1; mem_rd = 3; mem_data = 32'h33; rr2 = 3;
        cyc(); idle();
        chk("sb_haz1", 64'(hazard), 64'd1);
        cyc();
        chk("sb_haz2", 64'(hazard), 64'd1);
        mem_valid = 1; mem_rd = 3;
        cyc(); idle(); rr2 = 0; cyc();

        // Reset while FIFO holds 3 entries and r4 is busy
        ld_issue = 1; ld_rd = 4; mem_valid = 1; mem_rd = 0;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'(i);
            cyc(); ld_issue = 0;
        end
        alu_valid = 0; rr1 = 4;
        chk("pre_rst_count", 64'(fifo_count), 64'd3);
        mem_rd = 4; reset = 1;
        cyc(); idle(); reset = 0;
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_haz", 64'(hazard), 64'd0);
        chk("rst_we", 64'(rf_regwrite), 64'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_jal   = ($urandom_range(0, 99) < 10);
            alu_data  = $urandom;
            ld_issue  = ($urandom_range(0, 99) < 15);
            ld_rd     = 5'($urandom_range(0, 31));
            mem_valid = ($urandom_range(0, 99) < 30);
            mem_rd    = 5'($urandom_range(0, 31));
            mem_data  = $urandom;
            rr1       = 5'($urandom_range(0, 31));
            rr2       = 5'($urandom_range(0, 31));
            reset     = ($urandom_range(0, 999) < 3);
            cyc();
        end
        reset = 0; idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - ALU/JAL results, buffered in a small FIFO.
  - Memory load returns, which always have priority.
- Keeps a per-register pending-load scoreboard and raises a hazard flag for the decode stage.
- Drives the register file's regwrite, write-address and write-data inputs from registered outputs.

Parameters:
W, 32, data width of writeback values
DEPTH, 4, ALU writeback FIFO entries (power of two, >=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle when alu_valid&&alu_ready
alu_rd  in  5  ALU destination register
alu_jal  in  1  destination forced to r31
alu_data  in  W  ALU result
ld_issue  in  1  load issued to memory this cycle
ld_rd  in  5  load destination register
mem_valid  in  1  load data returning (always accepted)
mem_rd  in  5  load destination register
mem_data  in  W  load data
rr1  in  5  decode read address 1
rr2  in  5  decode read address 2
hazard  out  1  read of a not-yet-written register; decode must stall
rf_regwrite  out  1  register file write enable
rf_wr  out  5  register file write address
rf_wdata  out  W  register file write data
fifo_count  out  $clog2(DEPTH)+1  ALU FIFO occupancy

Behaviour:
- Reset: synchronous, active-high, on clock.
  - rf_regwrite=0, rf_wr=0, rf_wdata=0.
  - FIFO emptied; fifo_count=0.
  - Busy vector cleared.
  - Reset wins over all same-cycle events, including an in-flight load return, which is dropped.
- Effective ALU destination: erd = alu_jal ? 31 : alu_rd.
- alu_ready (combinational) = (fifo_count<DEPTH) && !busy[erd].
  - An ALU write to a register with a pending load is held off; this prevents WAW reordering.
  - No pop-through when full.
- Accepted ALU request with erd==0: consumed but not enqueued.
- Accepted ALU request with erd!=0: enqueued {erd, alu_data} in arrival order.
- Output stage, evaluated at each clock edge (one winner per cycle):
  - mem_valid: output register loads {1, mem_rd, mem_data}. If mem_rd==0, rf_regwrite=0 instead.
  - else if FIFO non-empty: pop head; output register loads {1, head.rd, head.data}.
  - else: rf_regwrite=0; rf_wr and rf_wdata hold their previous values.
- Latency:
  - Load return reaches the rf_* outputs the cycle after mem_valid.
  - ALU result into an empty FIFO, with no mem_valid, is popped the following cycle.
  - So an ALU write appears on rf_* 2 cycles after acceptance at minimum.
  - A continuous mem_valid stream starves the FIFO; this is allowed, as the memory side is bounded by issue.
- Enqueue and pop in the same cycle: both happen; fifo_count unchanged.
- Pointers wrap modulo DEPTH.
- Scoreboard (busy[31:0]; busy[0] is hard-wired 0):
  - ld_issue with ld_rd!=0 sets busy[ld_rd].
  - mem_valid clears busy[mem_rd].
  - Same register set and cleared in one cycle: set wins (a new load is outstanding).
  - mem_valid to a non-busy register: written anyway; scoreboard unchanged.
- hazard (combinational) is asserted for a nonzero rrX (X = 1 or 2) if any of these hold:
  - busy[rrX].
  - Any valid FIFO entry has rd==rrX.
  - rf_regwrite && rf_wr==rrX.
  - rr==0 never causes a hazard.

Test Plan:
- Reset, then ALU erd=5 data=0x11 in cycle 0 -> rf_regwrite=1, rf_wr=5, rf_wdata=0x11 in cycle 2; hazard for rr1=5 high in cycles 1-2, low in cycle 3.
- ALU request alu_rd=7, alu_jal=1, data=0x400 -> written to r31; ALU request erd=0 -> accepted, no rf_regwrite pulse.
- ld_issue ld_rd=9; ALU erd=9 -> alu_ready=0 until mem_valid mem_rd=9 data=0xAB; rf_wr=9, rf_wdata=0xAB next cycle, then the ALU write to r9 follows.
- 4 ALU requests with mem_valid held high 6 cycles -> fifo_count reaches 4, alu_ready=0 on the 5th; after mem_valid drops, FIFO entries drain in order, one per cycle.
- ld_issue ld_rd=3 and mem_valid mem_rd=3 in the same cycle -> busy[3] remains set; hazard for rr2=3 stays 1.
- Reset asserted while FIFO holds 3 entries and busy[4]=1 -> next cycle fifo_count=0, hazard=0, rf_regwrite=0.
